// File: rtl/dispense_scheduler.sv
// dispense_scheduler: time-of-day matched, per-channel dose pulse engine with ack/timeout alarm.
module dispense_scheduler #(
    parameter int unsigned CHANNELS   = 2,
    parameter int unsigned SLOTS      = 3,
    parameter int unsigned DOSE_W     = 3,
    parameter int unsigned PULSE_HIGH = 4,
    parameter int unsigned PULSE_LOW  = 4,
    parameter int unsigned ALARM_SECS = 60,
    localparam int unsigned SLOT_W    = (SLOTS > 1) ? $clog2(SLOTS) : 1,
    localparam int unsigned CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                second_tick,
    input  logic [4:0]          hours,
    input  logic [5:0]          minutes,
    input  logic [5:0]          seconds,
    input  logic                cfg_slot_we,
    input  logic                cfg_dose_we,
    input  logic [SLOT_W-1:0]   cfg_slot,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [4:0]          cfg_hours,
    input  logic [5:0]          cfg_minutes,
    input  logic                cfg_enable,
    input  logic [DOSE_W-1:0]   cfg_dose,
    input  logic                ack,
    output logic [CHANNELS-1:0] dispense,
    output logic [SLOT_W-1:0]   active_slot,
    output logic                busy,
    output logic                alarm,
    output logic                overrun,
    output logic [7:0]          missed_count
);
    localparam int unsigned PULSE_MAX = (PULSE_HIGH > PULSE_LOW) ? PULSE_HIGH : PULSE_LOW;
    localparam int unsigned CNT_W     = (PULSE_MAX > 1) ? $clog2(PULSE_MAX) : 1;
    localparam int unsigned SEC_W     = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;

    typedef enum logic [1:0] {IDLE, DISPENSE, ALARM} state_t;

    state_t              state;
    logic                slot_en      [SLOTS];
    logic [4:0]          slot_hours   [SLOTS];
    logic [5:0]          slot_minutes [SLOTS];
    logic [DOSE_W-1:0]   dose         [SLOTS][CHANNELS];

    logic                sample_valid;
    logic [4:0]          hours_q;
    logic [5:0]          minutes_q;
    logic                match_valid;
    logic [SLOT_W-1:0]   match_slot;
    logic                pending;
    logic [SLOT_W-1:0]   pending_slot;
    logic [CH_W-1:0]     ch;
    logic [DOSE_W-1:0]   pulses_left;
    logic                high_phase;
    logic                zero_ch;
    logic [CNT_W-1:0]    cnt;
    logic [SEC_W-1:0]    sec_cnt;
    logic [CHANNELS-1:0] dispense_q;

    logic                hit;
    logic [SLOT_W-1:0]   hit_slot;
    logic                launch;
    logic [SLOT_W-1:0]   launch_slot;
    logic [SLOT_W-1:0]   dose_slot;
    logic [CH_W-1:0]     next_ch;
    logic [DOSE_W-1:0]   start_dose;
    logic [CHANNELS-1:0] start_mask;
    logic [CHANNELS-1:0] cur_mask;
    logic                ch_done;
    logic                last_ch;
    logic                slot_ok;
    logic                ch_ok;

    // Actuators drop the moment reset is raised rather than waiting for the edge.
    assign dispense = dispense_q & {CHANNELS{~reset}};

    // Lowest-index enabled slot equal to the sampled time; hours past 23 never match.
    always_comb begin
        hit      = 1'b0;
        hit_slot = '0;
        for (int s = int'(SLOTS) - 1; s >= 0; s--) begin
            if (slot_en[s] && (slot_hours[s] <= 5'd23) &&
                (slot_hours[s] == hours_q) && (slot_minutes[s] == minutes_q)) begin
                hit      = 1'b1;
                hit_slot = SLOT_W'(s);
            end
        end
    end

    // Launch selection, channel sequencing and config range checks.
    always_comb begin
        launch      = (state == IDLE) && (pending || match_valid);
        launch_slot = pending ? pending_slot : match_slot;
        next_ch     = (state == IDLE) ? '0 : ch + CH_W'(1);
        dose_slot   = (state == IDLE) ? launch_slot : active_slot;
        start_dose  = dose[dose_slot][next_ch];
        start_mask  = CHANNELS'(1) << next_ch;
        cur_mask    = CHANNELS'(1) << ch;
        ch_done     = zero_ch || (!high_phase && (cnt == '0) && (pulses_left == DOSE_W'(1)));
        last_ch     = (ch == CH_W'(CHANNELS - 1));
        slot_ok     = ({1'b0, cfg_slot} < (SLOT_W + 1)'(SLOTS));
        ch_ok       = ({1'b0, cfg_ch} < (CH_W + 1)'(CHANNELS));
    end

    // Table, match pipeline, queueing and the IDLE/DISPENSE/ALARM sequencer.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int s = 0; s < int'(SLOTS); s++) begin
                slot_en[s]      <= 1'b0;
                slot_hours[s]   <= '0;
                slot_minutes[s] <= '0;
                for (int c = 0; c < int'(CHANNELS); c++) dose[s][c] <= '0;
            end
            state        <= IDLE;
            sample_valid <= 1'b0;
            hours_q      <= '0;
            minutes_q    <= '0;
            match_valid  <= 1'b0;
            match_slot   <= '0;
            pending      <= 1'b0;
            pending_slot <= '0;
            ch           <= '0;
            pulses_left  <= '0;
            high_phase   <= 1'b0;
            zero_ch      <= 1'b0;
            cnt          <= '0;
            sec_cnt      <= '0;
            dispense_q   <= '0;
            active_slot  <= '0;
            busy         <= 1'b0;
            alarm        <= 1'b0;
            overrun      <= 1'b0;
            missed_count <= '0;
        end else begin
            sample_valid <= second_tick && (seconds == 6'd0);
            hours_q      <= hours;
            minutes_q    <= minutes;
            match_valid  <= sample_valid && hit;
            match_slot   <= hit_slot;

            if ((state == IDLE) && cfg_slot_we && slot_ok) begin
                slot_en[cfg_slot]      <= cfg_enable;
                slot_hours[cfg_slot]   <= cfg_hours;
                slot_minutes[cfg_slot] <= cfg_minutes;
            end
            if ((state == IDLE) && cfg_dose_we && slot_ok && ch_ok)
                dose[cfg_slot][cfg_ch] <= cfg_dose;

            case (state)
                IDLE: begin
                    if (launch) begin
                        state       <= DISPENSE;
                        busy        <= 1'b1;
                        active_slot <= launch_slot;
                        ch          <= '0;
                        zero_ch     <= (start_dose == '0);
                        pulses_left <= start_dose;
                        high_phase  <= 1'b1;
                        cnt         <= CNT_W'(PULSE_HIGH - 1);
                        dispense_q  <= (start_dose == '0) ? '0 : start_mask;
                        // A match landing on a pending launch queues behind it.
                        pending     <= pending && match_valid;
                        if (pending && match_valid) pending_slot <= match_slot;
                    end
                end
                DISPENSE: begin
                    if (ch_done) begin
                        if (last_ch) begin
                            state      <= ALARM;
                            alarm      <= 1'b1;
                            sec_cnt    <= '0;
                            dispense_q <= '0;
                        end else begin
                            ch          <= next_ch;
                            zero_ch     <= (start_dose == '0);
                            pulses_left <= start_dose;
                            high_phase  <= 1'b1;
                            cnt         <= CNT_W'(PULSE_HIGH - 1);
                            dispense_q  <= (start_dose == '0) ? '0 : start_mask;
                        end
                    end else if (high_phase) begin
                        if (cnt == '0) begin
                            high_phase <= 1'b0;
                            cnt        <= CNT_W'(PULSE_LOW - 1);
                            dispense_q <= '0;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end else begin
                        if (cnt == '0) begin
                            pulses_left <= pulses_left - DOSE_W'(1);
                            high_phase  <= 1'b1;
                            cnt         <= CNT_W'(PULSE_HIGH - 1);
                            dispense_q  <= cur_mask;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                end
                ALARM: begin
                    if (ack) begin
                        state <= IDLE;
                        alarm <= 1'b0;
                        busy  <= 1'b0;
                    end else if (second_tick) begin
                        if (sec_cnt == SEC_W'(ALARM_SECS - 1)) begin
                            state <= IDLE;
                            alarm <= 1'b0;
                            busy  <= 1'b0;
                            if (missed_count != 8'hFF) missed_count <= missed_count + 8'd1;
                        end else begin
                            sec_cnt <= sec_cnt + SEC_W'(1);
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    alarm      <= 1'b0;
                    dispense_q <= '0;
                end
            endcase

            // Matches while occupied: hold one, drop any further ones.
            if ((state != IDLE) && match_valid) begin
                if (!pending) begin
                    pending      <= 1'b1;
                    pending_slot <= match_slot;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_dispense_scheduler.sv
// tb_dispense_scheduler: directed checks of matching, pulse timing, alarm, queueing and reset.
module tb_dispense_scheduler;
    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic       second_tick;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       cfg_slot_we;
    logic       cfg_dose_we;
    logic [1:0] cfg_slot;
    logic [0:0] cfg_ch;
    logic [4:0] cfg_hours;
    logic [5:0] cfg_minutes;
    logic       cfg_enable;
    logic [2:0] cfg_dose;
    logic       ack;
    logic [1:0] dispense;
    logic [1:0] active_slot;
    logic       busy;
    logic       alarm;
    logic       overrun;
    logic [7:0] missed_count;

    int checks = 0;
    int errors = 0;

    dispense_scheduler #(
        .CHANNELS(2), .SLOTS(3), .DOSE_W(3),
        .PULSE_HIGH(4), .PULSE_LOW(4), .ALARM_SECS(3)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .second_tick(second_tick),
        .hours(hours), .minutes(minutes), .seconds(seconds),
        .cfg_slot_we(cfg_slot_we), .cfg_dose_we(cfg_dose_we),
        .cfg_slot(cfg_slot), .cfg_ch(cfg_ch), .cfg_hours(cfg_hours),
        .cfg_minutes(cfg_minutes), .cfg_enable(cfg_enable), .cfg_dose(cfg_dose),
        .ack(ack), .dispense(dispense), .active_slot(active_slot), .busy(busy),
        .alarm(alarm), .overrun(overrun), .missed_count(missed_count)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic write_slot(input int s, input int h, input int m, input logic en);
        cfg_slot = 2'(s); cfg_hours = 5'(h); cfg_minutes = 6'(m); cfg_enable = en;
        cfg_slot_we = 1'b1;
        step(1);
        cfg_slot_we = 1'b0;
    endtask

    task automatic write_dose(input int s, input int c, input int d);
        cfg_slot = 2'(s); cfg_ch = 1'(c); cfg_dose = 3'(d);
        cfg_dose_we = 1'b1;
        step(1);
        cfg_dose_we = 1'b0;
    endtask

    task automatic tick(input int h, input int m, input int s);
        hours = 5'(h); minutes = 6'(m); seconds = 6'(s);
        second_tick = 1'b1;
        step(1);
        second_tick = 1'b0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        step(1);
        ack = 1'b0;
    endtask

    initial begin
        logic [1:0] exp_disp;
        reset = 1'b1; second_tick = 1'b0; hours = '0; minutes = '0; seconds = '0;
        cfg_slot_we = 1'b0; cfg_dose_we = 1'b0; cfg_slot = '0; cfg_ch = '0;
        cfg_hours = '0; cfg_minutes = '0; cfg_enable = 1'b0; cfg_dose = '0; ack = 1'b0;
        step(2);
        check("rst_dispense", 32'(dispense), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_alarm", 32'(alarm), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_missed", 32'(missed_count), 32'd0);
        check("rst_active_slot", 32'(active_slot), 32'd0);
        reset = 1'b0;

        // Slot0 08:00, doses 2/1, acknowledged.
        write_slot(0, 8, 0, 1'b1);
        write_dose(0, 0, 2);
        write_dose(0, 1, 1);
        tick(8, 0, 0);
        check("lat_busy_k", 32'(busy), 32'd0);
        step(1);
        check("lat_busy_k1", 32'(busy), 32'd0);
        step(1);
        check("lat_busy_k2", 32'(busy), 32'd1);
        check("lat_active_slot", 32'(active_slot), 32'd0);
        for (int i = 0; i < 24; i++) begin
            if (i < 4 || (i >= 8 && i < 12)) exp_disp = 2'b01;
            else if (i >= 16 && i < 20)      exp_disp = 2'b10;
            else                             exp_disp = 2'b00;
            check($sformatf("wave_%0d", i), 32'(dispense), 32'(exp_disp));
            step(1);
        end
        check("t1_alarm", 32'(alarm), 32'd1);
        check("t1_busy_alarm", 32'(busy), 32'd1);
        pulse_ack();
        check("t1_ack_alarm", 32'(alarm), 32'd0);
        check("t1_ack_busy", 32'(busy), 32'd0);
        check("t1_missed", 32'(missed_count), 32'd0);

        // Same slot, no ack: timeout after three ticks.
        tick(8, 0, 0);
        step(26);
        check("t2_alarm", 32'(alarm), 32'd1);
        tick(8, 0, 1);
        check("t2_tick1", 32'(alarm), 32'd1);
        tick(8, 0, 2);
        check("t2_tick2", 32'(alarm), 32'd1);
        tick(8, 0, 3);
        check("t2_timeout_alarm", 32'(alarm), 32'd0);
        check("t2_timeout_busy", 32'(busy), 32'd0);
        check("t2_missed1", 32'(missed_count), 32'd1);
        for (int i = 0; i < 255; i++) begin
            tick(8, 0, 0);
            step(26);
            tick(8, 0, 1);
            tick(8, 0, 2);
            tick(8, 0, 3);
            check("t2_missed_sat", 32'(missed_count), (i + 2 > 255) ? 32'd255 : 32'(i + 2));
        end

        // Two slots at 12:30: lowest index serviced, nothing queued.
        write_slot(0, 12, 30, 1'b1);
        write_slot(2, 12, 30, 1'b1);
        write_dose(2, 0, 1);
        tick(12, 30, 0);
        step(2);
        check("t3_busy", 32'(busy), 32'd1);
        check("t3_active_slot", 32'(active_slot), 32'd0);
        step(24);
        check("t3_alarm", 32'(alarm), 32'd1);
        pulse_ack();
        step(2);
        check("t3_no_requeue", 32'(busy), 32'd0);
        check("t3_overrun", 32'(overrun), 32'd0);

        // Long slot1 at 09:00, slot2 at 09:01 queued, third match overruns.
        write_slot(0, 0, 0, 1'b0);
        write_slot(1, 9, 0, 1'b1);
        write_dose(1, 0, 7);
        write_dose(1, 1, 7);
        write_slot(2, 9, 1, 1'b1);
        write_dose(2, 0, 0);
        write_dose(2, 1, 0);
        tick(9, 0, 0);
        step(2);
        check("t4_busy", 32'(busy), 32'd1);
        check("t4_active_slot1", 32'(active_slot), 32'd1);
        check("t4_dispense", 32'(dispense), 32'd1);
        step(10);
        tick(9, 1, 0);
        step(5);
        write_slot(0, 10, 0, 1'b1);
        tick(9, 0, 0);
        step(1);
        check("t4_overrun_pre", 32'(overrun), 32'd0);
        step(1);
        check("t4_overrun", 32'(overrun), 32'd1);
        step(92);
        check("t4_alarm1", 32'(alarm), 32'd1);
        check("t4_alarm1_slot", 32'(active_slot), 32'd1);
        pulse_ack();
        check("t4_gap_busy", 32'(busy), 32'd0);
        check("t4_gap_alarm", 32'(alarm), 32'd0);
        step(1);
        check("t4_relaunch_busy", 32'(busy), 32'd1);
        check("t4_relaunch_slot", 32'(active_slot), 32'd2);
        check("t4_zero_dispense", 32'(dispense), 32'd0);
        step(1);
        check("t4_zero_ch1_alarm", 32'(alarm), 32'd0);
        check("t4_zero_ch1_busy", 32'(busy), 32'd1);
        step(1);
        check("t4_zero_alarm", 32'(alarm), 32'd1);
        pulse_ack();
        step(2);
        check("t4_dropped", 32'(busy), 32'd0);
        check("t4_overrun_sticky", 32'(overrun), 32'd1);
        tick(10, 0, 0);
        step(2);
        check("t4_cfg_blocked", 32'(busy), 32'd0);

        // Reset mid-pulse.
        write_slot(0, 11, 0, 1'b1);
        tick(11, 0, 0);
        step(2);
        check("t5_pulse", 32'(dispense), 32'd1);
        step(1);
        reset = 1'b1;
        #1;
        check("t5_dispense_now", 32'(dispense), 32'd0);
        step(1);
        check("t5_dispense", 32'(dispense), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_alarm", 32'(alarm), 32'd0);
        check("t5_overrun", 32'(overrun), 32'd0);
        check("t5_missed", 32'(missed_count), 32'd0);
        reset = 1'b0;
        tick(11, 0, 0);
        step(2);
        check("t5_no_trigger", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dispense_scheduler.md
# dispense_scheduler

Parametrised per-slot, per-channel medication dispense engine for the pill dispenser. It compares a programmable table of SLOTS dose times against the running time of day and, on a match, drives step pulses to CHANNELS dispenser actuators. Each channel receives its own programmed dose count per slot. After dispensing it raises an alarm until the patient acknowledges or the alarm times out, and it counts missed doses. It replaces the fixed morning/afternoon/evening pulse logic and the per-dispenser fixed-mode controllers, and sits between the time-of-day counters and the actuator/alarm outputs.

## Interface
Parameters:
- CHANNELS, 2: number of dispenser actuators.
- SLOTS, 3: number of programmable dose times.
- DOSE_W, 3: width of a per-channel, per-slot dose count.
- PULSE_HIGH, 4: cycles each actuator pulse is high.
- PULSE_LOW, 4: cycles of low gap after each pulse.
- ALARM_SECS, 60: second_tick count before an unacknowledged alarm times out.
- Derived widths: SLOT_W = max(1, clog2(SLOTS)); CH_W = max(1, clog2(CHANNELS)).

Ports:
- CLOCK_50  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- second_tick  in  1  one-cycle pulse, once per second.
- hours  in  5  time of day, 0–23.
- minutes  in  6  time of day, 0–59.
- seconds  in  6  time of day, 0–59.
- cfg_slot_we  in  1  write {cfg_enable, cfg_hours, cfg_minutes} into slot cfg_slot.
- cfg_dose_we  in  1  write cfg_dose into dose[cfg_slot][cfg_ch].
- cfg_slot  in  SLOT_W  target slot.
- cfg_ch  in  CH_W  target channel.
- cfg_hours  in  5  slot hour.
- cfg_minutes  in  6  slot minute.
- cfg_enable  in  1  slot enable.
- cfg_dose  in  DOSE_W  dose count.
- ack  in  1  one-cycle acknowledge pulse.
- dispense  out  CHANNELS  actuator step pulses.
- active_slot  out  SLOT_W  slot being serviced.
- busy  out  1  high when the FSM is not in IDLE.
- alarm  out  1  high in the ALARM state.
- overrun  out  1  sticky flag: a dose time was dropped.
- missed_count  out  8  saturating count of timed-out alarms.

## Operation
- Reset: all slots disabled, with hours, minutes and doses at 0. All outputs and counters go to 0. The FSM goes to IDLE and the pending flag is cleared. Reset asserted mid-dispense or mid-alarm takes effect at the next edge, and dispense goes to 0 immediately.
- Config writes: accepted only in IDLE; ignored otherwise. cfg_slot ≥ SLOTS or cfg_ch ≥ CHANNELS is ignored.
- Match detection:
  - Evaluated only on a cycle where second_tick=1 and seconds==0, so at most one match per minute.
  - A slot matches when it is enabled, hours equals its hour and minutes equals its minute.
  - If several slots match, the lowest index wins; the others are silently ignored.
  - Slot hours > 23 never match.
- The match result is registered into match_valid/match_slot.
- FSM states: IDLE, DISPENSE, ALARM.
  - IDLE → DISPENSE when match_valid or pending is set. Pending has priority and is cleared on launch. active_slot is loaded.
  - DISPENSE: channels are serviced in order 0..CHANNELS-1. Channel c with dose d>0 emits d pulses; each pulse is PULSE_HIGH cycles high then PULSE_LOW cycles low, and only dispense[c] can be high. A channel with d=0 consumes exactly 1 cycle with no pulse. After the last channel, go to ALARM.
  - ALARM: alarm=1 and second_tick is counted. On ack go to IDLE. When ALARM_SECS ticks have been counted, increment missed_count (saturating at 255) and go to IDLE. If ack and the final tick arrive in the same cycle, ack wins and there is no miss. ack in other states is ignored.
- Match while busy:
  - If pending is clear, set pending and store the slot.
  - If pending is already set, drop the match and set overrun=1 (sticky until reset).
- Dose values are read from the table as each channel starts. The table is stable while busy because writes are blocked.

## Timing
- A qualifying second_tick sampled at edge k causes match_valid=1 after edge k+1. After edge k+2: busy=1, active_slot valid, and dispense[0] high if dose>0.
- Dispense duration = Σc (dose_c·(PULSE_HIGH+PULSE_LOW), or 1 if dose_c=0) cycles, with no gap cycles between channels.
- alarm rises at the edge that ends DISPENSE. It falls, and busy falls, at the edge that samples ack=1 or the final timeout tick.
- Pending launch: busy stays low for exactly 1 cycle in IDLE, then re-enters DISPENSE.
- missed_count updates at the same edge alarm falls.

## Test plan
- Slot0 = 08:00 enabled, dose ch0=2, ch1=1, PULSE 4/4. Tick at 08:00:00 → dispense[0] shows two 4-cycle highs, then dispense[1] shows one. busy is high for 24 cycles, then alarm=1. ack → alarm=0, missed_count=0.
- Same setup, no ack, ALARM_SECS=3 → alarm falls after the 3rd tick and missed_count=1. Repeat 256 times → missed_count holds at 255.
- Slots 0 and 2 both at 12:30 → only slot 0 is serviced (active_slot=0) and overrun=0.
- Slot1 at 09:00 with a long dose still dispensing when slot2 at 09:01 matches → slot2 runs after the slot1 ack, with 1 IDLE cycle between. A third match during that window → overrun=1.
- cfg_slot_we while busy → table unchanged. Slot with all doses 0 → busy for CHANNELS cycles, then alarm.
- Reset asserted mid-pulse → dispense, busy and alarm are 0 next cycle, and a previously matching time no longer triggers.
